// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: program counter, instruction-memory address and the
// IF/ID pipeline register, with stall, branch redirect/flush and fetch-halt.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inStall,
  input  logic        inBranchTaken,
  input  logic [31:0] inBranchTarget,
  input  logic [31:0] inImemData,
  output logic [31:0] outImemAddr,
  output logic [31:0] outInstruction,
  output logic [31:0] outPCPlus4,
  output logic        outValid,
  output logic        outHalted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcplus4;
  logic        ifid_valid;
  logic        unused_tgt;

  // Redirect targets are word-aligned; the low two bits are dropped.
  assign unused_tgt = ^inBranchTarget[1:0];
  assign pc_plus4   = pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      pc           <= RESET_PC;
      ifid_instr   <= '0;
      ifid_pcplus4 <= '0;
      ifid_valid   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (inBranchTaken) begin
            pc         <= {inBranchTarget[31:2], 2'b00};
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
          end else if (!inStall) begin
            if (inImemData == HALT_WORD) begin
              // PC stays on the halt word; the bubble keeps the old PC+4.
              ifid_instr <= '0;
              ifid_valid <= 1'b0;
              state      <= HALTED;
            end else begin
              pc           <= pc_plus4;
              ifid_instr   <= inImemData;
              ifid_pcplus4 <= pc_plus4;
              ifid_valid   <= 1'b1;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign outImemAddr    = pc;
  assign outInstruction = ifid_instr;
  assign outPCPlus4     = ifid_pcplus4;
  assign outValid       = ifid_valid;
  assign outHalted      = (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: free run, stall, branch,
// halt, asynchronous reset and PC wrap-around with a non-zero reset PC.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        inStall;
  logic        inBranchTaken;
  logic [31:0] inBranchTarget;
  logic [31:0] inImemData;
  logic [31:0] outImemAddr;
  logic [31:0] outInstruction;
  logic [31:0] outPCPlus4;
  logic        outValid;
  logic        outHalted;

  logic        rst_w;
  logic [31:0] w_imem;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;
  logic        w_halted;

  int checks;
  int failures;

  instruction_fetch u_dut (
    .clk            (clk),
    .rst            (rst),
    .inStall        (inStall),
    .inBranchTaken  (inBranchTaken),
    .inBranchTarget (inBranchTarget),
    .inImemData     (inImemData),
    .outImemAddr    (outImemAddr),
    .outInstruction (outInstruction),
    .outPCPlus4     (outPCPlus4),
    .outValid       (outValid),
    .outHalted      (outHalted)
  );

  instruction_fetch #(
    .RESET_PC  (32'hFFFF_FFF8),
    .HALT_WORD (32'hFFFF_FFFF)
  ) u_wrap (
    .clk            (clk),
    .rst            (rst_w),
    .inStall        (1'b0),
    .inBranchTaken  (1'b0),
    .inBranchTarget (32'h0),
    .inImemData     (w_imem),
    .outImemAddr    (w_addr),
    .outInstruction (w_instr),
    .outPCPlus4     (w_pc4),
    .outValid       (w_valid),
    .outHalted      (w_halted)
  );

  // Combinational instruction ROMs.
  always_comb begin
    case (outImemAddr)
      32'h0000_0000: inImemData = 32'h8C01_0004;
      32'h0000_0004: inImemData = 32'h0022_1820;
      32'h0000_0008: inImemData = 32'hAC03_0008;
      32'h0000_000C: inImemData = 32'h1000_0002;
      32'h0000_0010: inImemData = 32'hFFFF_FFFF;
      32'h0000_0040: inImemData = 32'h2042_0001;
      32'h0000_0044: inImemData = 32'h2063_0002;
      default:       inImemData = 32'h0000_0000;
    endcase
  end

  always_comb begin
    case (w_addr)
      32'hFFFF_FFF8: w_imem = 32'h1111_1111;
      32'hFFFF_FFFC: w_imem = 32'h2222_2222;
      32'h0000_0000: w_imem = 32'h3333_3333;
      default:       w_imem = 32'h0000_0000;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid, input logic halted);
    chk({tag, ".addr"},   outImemAddr,    addr);
    chk({tag, ".instr"},  outInstruction, instr);
    chk({tag, ".pc4"},    outPCPlus4,     pc4);
    chk({tag, ".valid"},  {31'b0, outValid},  {31'b0, valid});
    chk({tag, ".halted"}, {31'b0, outHalted}, {31'b0, halted});
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    rst_w          = 1'b1;
    inStall        = 1'b0;
    inBranchTaken  = 1'b0;
    inBranchTarget = 32'h0;
    #1;
    rst   = 1'b0;
    rst_w = 1'b0;
    #1;
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first_addr", outImemAddr, 32'h0);

    step();
    chk_ifid("run0", 32'h4, 32'h8C01_0004, 32'h4, 1'b1, 1'b0);
    step();
    chk_ifid("run1", 32'h8, 32'h0022_1820, 32'h8, 1'b1, 1'b0);

    inStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid("stall", 32'h8, 32'h0022_1820, 32'h8, 1'b1, 1'b0);
    end
    inStall = 1'b0;
    step();
    chk_ifid("resume", 32'hC, 32'hAC03_0008, 32'hC, 1'b1, 1'b0);

    // Branch wins over a simultaneous stall; target low bits are dropped.
    inStall        = 1'b1;
    inBranchTaken  = 1'b1;
    inBranchTarget = 32'h0000_0043;
    step();
    chk_ifid("br_flush", 32'h40, 32'h0, 32'hC, 1'b0, 1'b0);
    inStall       = 1'b0;
    inBranchTaken = 1'b0;
    step();
    chk_ifid("br_tgt", 32'h44, 32'h2042_0001, 32'h44, 1'b1, 1'b0);
    step();
    chk_ifid("br_next", 32'h48, 32'h2063_0002, 32'h48, 1'b1, 1'b0);

    inBranchTaken  = 1'b1;
    inBranchTarget = 32'h0000_0010;
    step();
    chk_ifid("to_halt", 32'h10, 32'h0, 32'h48, 1'b0, 1'b0);
    step();
    chk_ifid("halt_br", 32'h10, 32'h0, 32'h48, 1'b0, 1'b0);
    inBranchTaken = 1'b0;
    inStall       = 1'b1;
    step();
    chk_ifid("halt_stall", 32'h10, 32'h0, 32'h48, 1'b0, 1'b0);
    inStall = 1'b0;
    step();
    chk_ifid("halted", 32'h10, 32'h0, 32'h48, 1'b0, 1'b1);

    inBranchTarget = 32'h0000_0080;
    for (int i = 0; i < 20; i++) begin
      inBranchTaken = (i % 2) == 0;
      inStall       = (i % 4) >= 2;
      step();
      chk_ifid("hold", 32'h10, 32'h0, 32'h48, 1'b0, 1'b1);
    end
    inBranchTaken = 1'b0;
    inStall       = 1'b0;

    #2;
    rst = 1'b0;
    #1;
    chk_ifid("halt_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_ifid("rerun", 32'h4, 32'h8C01_0004, 32'h4, 1'b1, 1'b0);

    inStall = 1'b1;
    step();
    chk_ifid("pre_rst", 32'h4, 32'h8C01_0004, 32'h4, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_ifid("stall_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst     = 1'b1;
    inStall = 1'b0;

    rst_w = 1'b1;
    #1;
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
    step();
    chk("wrap0_addr",  w_addr,  32'hFFFF_FFFC);
    chk("wrap0_instr", w_instr, 32'h1111_1111);
    chk("wrap0_pc4",   w_pc4,   32'hFFFF_FFFC);
    step();
    chk("wrap1_addr",  w_addr,  32'h0000_0000);
    chk("wrap1_instr", w_instr, 32'h2222_2222);
    chk("wrap1_pc4",   w_pc4,   32'h0000_0000);
    step();
    chk("wrap2_addr",  w_addr,  32'h0000_0004);
    chk("wrap2_instr", w_instr, 32'h3333_3333);
    chk("wrap2_pc4",   w_pc4,   32'h0000_0004);
    chk("wrap2_valid", {31'b0, w_valid},  32'h1);
    chk("wrap2_halt",  {31'b0, w_halted}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
